// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4 slave that fronts a single-port word SRAM.
package axi_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RREQ  = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    // Only full-word INCR/FIXED bursts are served; anything else is answered with SLVERR.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != AXI_SIZE_WORD) || (burst == AXI_BURST_WRAP) || (burst == 2'b11);
    endfunction

    function automatic logic [1:0] resp_of(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word address and last-beat flag for the current burst beat; shared by read and write paths.
module axi_burst_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic [1:0]                burst,
    input  logic [7:0]                beat_cnt,
    input  logic [7:0]                len,
    output logic [MEM_ADDR_WIDTH-1:0] next_addr,
    output logic                      last_beat
);

    // INCR wraps at the top of memory through plain modulo arithmetic
    always_comb begin
        next_addr = addr;
        case (burst)
            AXI_BURST_INCR:  next_addr = addr + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
            AXI_BURST_FIXED: next_addr = addr;
            default:         next_addr = addr;
        endcase
        last_beat = (beat_cnt == len);
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave endpoint serving a 1-cycle-latency word SRAM, one transaction at a time.
module axi_sram_responder
    import axi_sram_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        aw_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    output logic                        aw_ready,
    input  logic                        w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    output logic                        w_ready,
    output logic                        b_valid,
    output logic [1:0]                  b_resp,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    input  logic                        b_ready,
    input  logic                        ar_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    output logic                        ar_ready,
    output logic                        r_valid,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    input  logic                        r_ready,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata
);

    state_e                      state_r;
    logic                        prio_w_r;
    logic                        err_r;
    logic                        rd_first_r;
    logic [AXI_ID_WIDTH-1:0]     id_r;
    logic [7:0]                  len_r;
    logic [7:0]                  beat_r;
    logic [1:0]                  burst_r;
    logic [MEM_ADDR_WIDTH-1:0]   addr_r;
    logic [MEM_ADDR_WIDTH-1:0]   next_addr_s;
    logic                        last_s;
    logic [AXI_DATA_WIDTH-1:0]   rdata_hold_r;
    logic                        grant_w_s;
    logic                        grant_r_s;
    logic                        w_beat_s;
    logic                        wlast_err_s;
    logic                        unused_s;

    axi_burst_addr_gen #(
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_r),
        .burst     (burst_r),
        .beat_cnt  (beat_r),
        .len       (len_r),
        .next_addr (next_addr_s),
        .last_beat (last_s)
    );

    // Round-robin grant on a tie, fixed grant otherwise; only offered while idle
    always_comb begin
        grant_w_s = 1'b0;
        grant_r_s = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_w_s = aw_valid && (!ar_valid || prio_w_r);
            grant_r_s = ar_valid && (!aw_valid || !prio_w_r);
        end else begin
            grant_w_s = 1'b0;
            grant_r_s = 1'b0;
        end
    end

    assign aw_ready    = grant_w_s;
    assign ar_ready    = grant_r_s;
    assign w_ready     = (state_r == ST_WRITE);
    assign w_beat_s    = w_ready && w_valid;
    assign wlast_err_s = w_beat_s && (w_last != last_s);
    assign b_user      = {AXI_USER_WIDTH{1'b0}};
    assign r_user      = {AXI_USER_WIDTH{1'b0}};
    assign unused_s    = ^{aw_addr, ar_addr, aw_user, ar_user, w_user};

    // The first data cycle forwards the SRAM output; later cycles replay the captured word
    assign r_data = rd_first_r ? (err_r ? {AXI_DATA_WIDTH{1'b0}} : mem_rdata) : rdata_hold_r;

    // SRAM request port: write beats pass straight through, reads issue from RREQ
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_r;
        mem_wdata = {AXI_DATA_WIDTH{1'b0}};
        mem_be    = {(AXI_DATA_WIDTH/8){1'b0}};
        if (state_r == ST_WRITE) begin
            mem_req   = w_valid && !err_r;
            mem_we    = w_valid && !err_r;
            mem_wdata = w_data;
            mem_be    = w_strb;
        end else if (state_r == ST_RREQ) begin
            mem_req = !err_r;
        end else begin
            mem_req = 1'b0;
        end
    end

    // Transaction FSM with registered response-channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            prio_w_r     <= 1'b1;
            err_r        <= 1'b0;
            rd_first_r   <= 1'b0;
            id_r         <= {AXI_ID_WIDTH{1'b0}};
            len_r        <= 8'd0;
            beat_r       <= 8'd0;
            burst_r      <= 2'b00;
            addr_r       <= {MEM_ADDR_WIDTH{1'b0}};
            rdata_hold_r <= {AXI_DATA_WIDTH{1'b0}};
            b_valid      <= 1'b0;
            b_resp       <= AXI_RESP_OKAY;
            b_id         <= {AXI_ID_WIDTH{1'b0}};
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_resp       <= AXI_RESP_OKAY;
            r_id         <= {AXI_ID_WIDTH{1'b0}};
        end else begin
            rd_first_r <= 1'b0;
            if (rd_first_r) begin
                rdata_hold_r <= err_r ? {AXI_DATA_WIDTH{1'b0}} : mem_rdata;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_w_s) begin
                        id_r    <= aw_id;
                        len_r   <= aw_len;
                        burst_r <= aw_burst;
                        addr_r  <= aw_addr[MEM_ADDR_WIDTH+1:2];
                        err_r   <= burst_err(aw_size, aw_burst);
                        beat_r  <= 8'd0;
                        state_r <= ST_WRITE;
                    end else if (grant_r_s) begin
                        id_r    <= ar_id;
                        len_r   <= ar_len;
                        burst_r <= ar_burst;
                        addr_r  <= ar_addr[MEM_ADDR_WIDTH+1:2];
                        err_r   <= burst_err(ar_size, ar_burst);
                        beat_r  <= 8'd0;
                        state_r <= ST_RREQ;
                    end
                    if (aw_valid && ar_valid) begin
                        prio_w_r <= !prio_w_r;
                    end
                end
                ST_WRITE: begin
                    if (w_beat_s) begin
                        err_r <= err_r || wlast_err_s;
                        if (last_s) begin
                            b_valid <= 1'b1;
                            b_id    <= id_r;
                            b_resp  <= resp_of(err_r || wlast_err_s);
                            state_r <= ST_WRESP;
                        end else begin
                            addr_r <= next_addr_s;
                            beat_r <= beat_r + 8'd1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RREQ: begin
                    r_valid    <= 1'b1;
                    r_last     <= last_s;
                    r_id       <= id_r;
                    r_resp     <= resp_of(err_r);
                    rd_first_r <= 1'b1;
                    state_r    <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (last_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            addr_r  <= next_addr_s;
                            beat_r  <= beat_r + 8'd1;
                            state_r <= ST_RREQ;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized bench for axi_sram_responder against a word-array reference of the SRAM contents.
module tb_axi_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aw_valid, aw_ready, w_valid, w_last, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_last, r_ready;
    logic [31:0] aw_addr, ar_addr, w_data, r_data, mem_wdata, mem_rdata;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [3:0]  aw_id, ar_id, b_id, r_id, w_strb, mem_be;
    logic [0:0]  aw_user, w_user, ar_user, b_user, r_user;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;

    logic [31:0] sram [4096];
    logic [31:0] ref_mem [4096];
    bit          init_done;
    int          n_checks = 0;
    int          n_errors = 0;

    axi_sram_responder dut (
        .clk(clk), .rst_n(rst_n),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_id(aw_id), .aw_user(aw_user), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_user(w_user), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_id(b_id), .b_user(b_user), .b_ready(b_ready),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_id(ar_id), .ar_user(ar_user), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_id(r_id), .r_user(r_user), .r_ready(r_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] seed_val(input logic [11:0] a);
        return {a, 4'h0, ~a, 4'h5};
    endfunction

    // SRAM: byte-enabled writes, registered reads, junk on idle cycles
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) sram[i] <= seed_val(12'(i));
            init_done <= 1'b1;
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else if (mem_req) begin
            mem_rdata <= sram[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || burst[1];
    endfunction

    function automatic logic [11:0] beat_addr(input logic [11:0] base, input logic [1:0] burst, input int i);
        return (burst == 2'b01) ? base + 12'(i) : base;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input logic [31:0] d0,
                             input bit seq, input bit early_last, input bit hold);
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          werr, wl;
        int          n;
        werr = model_err(size, burst);
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size;
        aw_burst = burst; aw_id = id; aw_user = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 20) begin @(negedge clk); n++; end
        check_val("aw_ready", 32'(aw_ready), 32'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0; aw_addr = $urandom; aw_len = 8'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            a  = beat_addr(addr[13:2], burst, i);
            d  = seq ? d0 + 32'(i) : $urandom;
            s  = seq ? 4'hF : 4'($urandom);
            wl = (i == int'(len)) || (early_last && i == 0);
            w_valid = 1'b1; w_data = d; w_strb = s; w_last = wl;
            @(negedge clk);
            check_val("w_ready", 32'(w_ready), 32'd1);
            check_val("w_mem_req", 32'(mem_req), 32'(!werr));
            if (!werr) begin
                check_val("w_mem_we", 32'(mem_we), 32'd1);
                check_val("w_mem_addr", 32'(mem_addr), 32'(a));
                check_val("w_mem_wdata", mem_wdata, d);
                check_val("w_mem_be", 32'(mem_be), 32'(s));
                ref_mem[a] = merge(ref_mem[a], d, s);
            end
            if (wl != (i == int'(len))) werr = 1'b1;
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_valid && n < 20) begin @(negedge clk); n++; end
        check_val("b_valid", 32'(b_valid), 32'd1);
        check_val("b_resp", 32'(b_resp), werr ? 32'd2 : 32'd0);
        check_val("b_id", 32'(b_id), 32'(id));
        if (hold) begin
            @(negedge clk);
            check_val("b_hold", 32'(b_valid), 32'd1);
        end
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        @(negedge clk);
        check_val("b_release", 32'(b_valid), 32'd0);
    endtask

    // Checks exact timing: request one cycle after AR, data the cycle after that
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input bit hold);
        logic [11:0] a;
        logic [31:0] exp_d;
        bit          rerr;
        int          n;
        rerr = model_err(size, burst);
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size;
        ar_burst = burst; ar_id = id; ar_user = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!ar_ready && n < 20) begin @(negedge clk); n++; end
        check_val("ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0; ar_addr = $urandom; ar_len = 8'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            a     = beat_addr(addr[13:2], burst, i);
            exp_d = rerr ? 32'd0 : ref_mem[a];
            @(negedge clk);
            check_val("r_mem_req", 32'(mem_req), 32'(!rerr));
            if (!rerr) check_val("r_mem_addr", 32'(mem_addr), 32'(a));
            check_val("r_valid_early", 32'(r_valid), 32'd0);
            @(negedge clk);
            check_val("r_valid", 32'(r_valid), 32'd1);
            check_val("r_data", r_data, exp_d);
            check_val("r_last", 32'(r_last), 32'(i == int'(len)));
            check_val("r_id", 32'(r_id), 32'(id));
            check_val("r_resp", 32'(r_resp), rerr ? 32'd2 : 32'd0);
            if (hold) begin
                @(negedge clk);
                check_val("r_hold_valid", 32'(r_valid), 32'd1);
                check_val("r_hold_data", r_data, exp_d);
            end
            r_ready = 1'b1;
            @(posedge clk); #1;
            r_ready = 1'b0;
        end
        @(negedge clk);
        check_val("r_release", 32'(r_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [11:0] base;
        logic [7:0]  ln;
        logic [1:0]  bu;
        logic [2:0]  sz;
        logic [3:0]  id;
        bit          gw, gr, early;
        int          n, r;

        rst_n = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_id = '0; aw_user = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; w_user = '0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_id = '0; ar_user = '0;
        r_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_val(12'(i));
        repeat (3) @(negedge clk);

        check_val("rst_aw_ready", 32'(aw_ready), 32'd0);
        check_val("rst_ar_ready", 32'(ar_ready), 32'd0);
        check_val("rst_w_ready", 32'(w_ready), 32'd0);
        check_val("rst_b_valid", 32'(b_valid), 32'd0);
        check_val("rst_r_valid", 32'(r_valid), 32'd0);
        check_val("rst_r_last", 32'(r_last), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_r_data", r_data, 32'd0);
        check_val("rst_b_resp", 32'(b_resp), 32'd0);
        check_val("rst_r_resp", 32'(r_resp), 32'd0);
        check_val("rst_b_id", 32'(b_id), 32'd0);
        check_val("rst_r_id", 32'(r_id), 32'd0);
        rst_n = 1'b1;

        axi_write(32'h10, 8'd0, 2'b01, 3'd2, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        axi_read (32'h10, 8'd0, 2'b01, 3'd2, 4'd5, 1'b0);
        axi_write(32'h20, 8'd3, 2'b01, 3'd2, 4'hA, 32'd1, 1'b1, 1'b0, 1'b1);
        axi_read (32'h20, 8'd3, 2'b01, 3'd2, 4'hA, 1'b1);
        axi_write(32'h3FFC, 8'd1, 2'b01, 3'd2, 4'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        axi_read (32'h3FFC, 8'd1, 2'b01, 3'd2, 4'd2, 1'b0);
        axi_write(32'h1C, 8'd2, 2'b00, 3'd2, 4'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        axi_read (32'h1C, 8'd2, 2'b00, 3'd2, 4'd4, 1'b1);
        axi_write(32'h40, 8'd1, 2'b10, 3'd2, 4'd6, 32'd0, 1'b0, 1'b0, 1'b0);
        axi_read (32'h40, 8'd1, 2'b01, 3'd1, 4'd7, 1'b0);
        axi_write(32'h60, 8'd1, 2'b01, 3'd2, 4'd8, 32'h77, 1'b1, 1'b1, 1'b0);
        axi_read (32'h60, 8'd1, 2'b01, 3'd2, 4'd8, 1'b0);

        for (int k = 0; k < 24; k++) begin
            ln = 8'($urandom_range(0, 5));
            r  = $urandom_range(0, 9);
            bu = (r < 3) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            base = ($urandom_range(0, 3) == 0) ? 12'(4095 - $urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
            a = $urandom;
            a[13:2] = base;
            id = 4'($urandom);
            early = (ln > 8'd0) && ($urandom_range(0, 7) == 0);
            axi_write(a, ln, bu, sz, id, 32'd0, 1'b0, early, 1'($urandom));
            axi_read(a, ln, bu, sz, ~id, 1'($urandom));
        end

        // Reset during the third beat of a four-beat write
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = 32'd50 << 2; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'b01; aw_id = 4'd3;
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 20) begin @(negedge clk); n++; end
        check_val("rm_aw_ready", 32'(aw_ready), 32'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_valid = 1'b1; w_data = 32'h5A00_0000 + 32'(i); w_strb = 4'hF; w_last = 1'b0;
            ref_mem[12'd50 + 12'(i)] = w_data;
            @(posedge clk); #1;
        end
        w_data = 32'h5A00_0002;
        @(negedge clk);
        check_val("rm_pre_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("rm_w_ready", 32'(w_ready), 32'd0);
        check_val("rm_b_valid", 32'(b_valid), 32'd0);
        check_val("rm_mem_req", 32'(mem_req), 32'd0);
        w_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_read(32'd50 << 2, 8'd3, 2'b01, 3'd2, 4'd9, 1'b0);

        // Simultaneous AW/AR held high: grants alternate starting with write
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = 32'd100 << 2; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01; aw_id = 4'd1;
        ar_valid = 1'b1; ar_addr = 32'd200 << 2; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01; ar_id = 4'd2;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!(aw_ready || ar_ready) && n < 20) begin @(negedge clk); n++; end
            gw = aw_ready;
            gr = ar_ready;
            check_val("arb_aw_ready", 32'(gw), 32'(k != 1));
            check_val("arb_ar_ready", 32'(gr), 32'(k == 1));
            @(posedge clk); #1;
            if (k == 2) begin aw_valid = 1'b0; ar_valid = 1'b0; end
            if (gw) begin
                w_valid = 1'b1; w_data = 32'hA5A5_0000 + 32'(k); w_strb = 4'hF; w_last = 1'b1;
                ref_mem[12'd100] = w_data;
                @(posedge clk); #1;
                w_valid = 1'b0; w_last = 1'b0;
                n = 0;
                @(negedge clk);
                while (!b_valid && n < 20) begin @(negedge clk); n++; end
                check_val("arb_b_valid", 32'(b_valid), 32'd1);
                check_val("arb_b_id", 32'(b_id), 32'd1);
                b_ready = 1'b1;
                @(posedge clk); #1;
                b_ready = 1'b0;
            end else if (gr) begin
                n = 0;
                @(negedge clk);
                while (!r_valid && n < 20) begin @(negedge clk); n++; end
                check_val("arb_r_valid", 32'(r_valid), 32'd1);
                check_val("arb_r_data", r_data, ref_mem[12'd200]);
                r_ready = 1'b1;
                @(posedge clk); #1;
                r_ready = 1'b0;
            end
        end
        aw_valid = 1'b0; ar_valid = 1'b0;
        axi_read(32'd100 << 2, 8'd0, 2'b01, 3'd2, 4'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
